// File: rtl/fir_frame_buffer_if.sv
// Handshake bundle between the FIR stage, the frame buffer and the FFT stage.
// The flush strobe exists only when FIR_FRAME_FLUSH_EN is defined.
interface fir_frame_buffer_if #(
  parameter int unsigned N = 16,
  parameter int unsigned W = 16
);
  logic           fir_valid;
  logic [W-1:0]   fir_d;
  logic           frame_valid;
  logic           frame_ready;
  logic [N*W-1:0] frame_data;
  logic [15:0]    frame_cnt;
  logic           overflow;
`ifdef FIR_FRAME_FLUSH_EN
  logic           flush;

  modport master (
    output fir_valid, fir_d, frame_ready, flush,
    input  frame_valid, frame_data, frame_cnt, overflow
  );
  modport slave (
    input  fir_valid, fir_d, frame_ready, flush,
    output frame_valid, frame_data, frame_cnt, overflow
  );
`else
  modport master (
    output fir_valid, fir_d, frame_ready,
    input  frame_valid, frame_data, frame_cnt, overflow
  );
  modport slave (
    input  fir_valid, fir_d, frame_ready,
    output frame_valid, frame_data, frame_cnt, overflow
  );
`endif
endinterface

// File: rtl/fir_frame_buffer.sv
// Ping-pong frame buffer: groups FIR samples into N-sample frames for the FFT stage.
// Optional zero-padding flush of a partial frame when FIR_FRAME_FLUSH_EN is defined.
module fir_frame_buffer #(
  parameter int unsigned N = 16,
  parameter int unsigned W = 16
) (
  input logic              clk,
  input logic              rst,
  fir_frame_buffer_if.slave bus
);
  localparam int unsigned PtrW = $clog2(N);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(N - 1);

  logic [W-1:0]    bank_q [2][N];
  logic [W-1:0]    bank_d [2][N];
  logic [1:0]      bank_full_q, bank_full_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic            wr_bank_q, wr_bank_d;
  logic            rd_bank_q, rd_bank_d;
  logic            frame_valid_q, frame_valid_d;
  logic [N*W-1:0]  frame_data_q, frame_data_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;
  logic            overflow_q, overflow_d;

  logic handoff, can_accept, accept, flush_go, complete, rd_sel;

  always_comb begin
    handoff    = frame_valid_q & bus.frame_ready;
    // A full write bank may still take a sample if it is being handed off this edge.
    can_accept = ~bank_full_q[wr_bank_q] | (handoff & (rd_bank_q == wr_bank_q));
    accept     = bus.fir_valid & can_accept;
`ifdef FIR_FRAME_FLUSH_EN
    flush_go   = bus.flush & (wr_ptr_q != '0) & can_accept;
`else
    flush_go   = 1'b0;
`endif
    complete   = (accept & (wr_ptr_q == LastPtr)) | flush_go;

    bank_d = bank_q;
    for (int unsigned i = 0; i < N; i++) begin
      if (accept && (PtrW'(i) == wr_ptr_q)) begin
        bank_d[wr_bank_q][PtrW'(i)] = bus.fir_d;
      end else if (flush_go && (PtrW'(i) >= wr_ptr_q)) begin
        bank_d[wr_bank_q][PtrW'(i)] = '0;
      end
    end

    bank_full_d = bank_full_q;
    rd_bank_d   = rd_bank_q;
    frame_cnt_d = frame_cnt_q;
    wr_ptr_d    = wr_ptr_q;
    wr_bank_d   = wr_bank_q;
    overflow_d  = overflow_q;

    // Clear before set so a bank freed and refilled in the same edge ends up full.
    if (handoff) begin
      bank_full_d[rd_bank_q] = 1'b0;
      rd_bank_d              = ~rd_bank_q;
      frame_cnt_d            = frame_cnt_q + 16'd1;
    end
    if (complete) begin
      wr_ptr_d               = '0;
      bank_full_d[wr_bank_q] = 1'b1;
      wr_bank_d              = ~wr_bank_q;
    end else if (accept) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (bus.fir_valid && !can_accept) begin
      overflow_d = 1'b1;
    end

    // On handoff look at the other bank so a full successor follows without a bubble.
    rd_sel        = handoff ? ~rd_bank_q : rd_bank_q;
    frame_valid_d = bank_full_q[rd_sel];
    frame_data_d  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      frame_data_d[k*W +: W] = bank_q[rd_sel][PtrW'(k)];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank_full_q   <= '0;
      wr_ptr_q      <= '0;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_data_q  <= '0;
      frame_cnt_q   <= '0;
      overflow_q    <= 1'b0;
    end else begin
      bank_full_q   <= bank_full_d;
      wr_ptr_q      <= wr_ptr_d;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      frame_valid_q <= frame_valid_d;
      frame_data_q  <= frame_data_d;
      frame_cnt_q   <= frame_cnt_d;
      overflow_q    <= overflow_d;
    end
  end

  // Sample storage carries no reset; the full flags alone define what is valid.
  always_ff @(posedge clk) begin
    bank_q <= bank_d;
  end

  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_data  = frame_data_q;
  assign bus.frame_cnt   = frame_cnt_q;
  assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_fir_frame_buffer.sv
// Directed self-checking bench for fir_frame_buffer (N=16, W=16).
// Define FIR_FRAME_FLUSH_EN to also exercise the flush scenario.
module tb_fir_frame_buffer;
  localparam int N = 16;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  fir_frame_buffer_if #(.N(N), .W(W)) bus ();

  fir_frame_buffer #(.N(N), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [N*W-1:0] ramp(input int base);
    logic [N*W-1:0] r;
    for (int k = 0; k < N; k++) r[k*W +: W] = W'(base + k);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int d);
    bus.fir_valid = 1'b1;
    bus.fir_d     = W'(d);
    step();
    bus.fir_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst             = 1'b0;
    bus.fir_valid   = 1'b0;
    bus.fir_d       = '0;
    bus.frame_ready = 1'b0;
`ifdef FIR_FRAME_FLUSH_EN
    bus.flush       = 1'b0;
`endif
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst             = 1'b0;
    bus.fir_valid   = 1'b0;
    bus.fir_d       = '0;
    bus.frame_ready = 1'b0;
`ifdef FIR_FRAME_FLUSH_EN
    bus.flush       = 1'b0;
`endif
    step();
    checks++;
    if (bus.frame_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got %b exp 0", bus.frame_valid);
    end
    checks++;
    if (bus.frame_data !== '0) begin
      errors++; $display("FAIL reset_data got %h exp 0", bus.frame_data);
    end
    checks++;
    if (bus.frame_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_cnt got %0d exp 0", bus.frame_cnt);
    end
    checks++;
    if (bus.overflow !== 1'b0) begin
      errors++; $display("FAIL reset_overflow got %b exp 0", bus.overflow);
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_single_frame();
    do_reset();
    bus.frame_ready = 1'b1;
    for (int i = 0; i < N; i++) push(i);
    checks++;
    if (bus.frame_valid !== 1'b0) begin
      errors++; $display("FAIL single_latency got %b exp 0", bus.frame_valid);
    end
    step();
    checks++;
    if (bus.frame_valid !== 1'b1) begin
      errors++; $display("FAIL single_valid got %b exp 1", bus.frame_valid);
    end
    checks++;
    if (bus.frame_data !== ramp(0)) begin
      errors++; $display("FAIL single_data got %h exp %h", bus.frame_data, ramp(0));
    end
    step();
    checks++;
    if (bus.frame_valid !== 1'b0) begin
      errors++; $display("FAIL single_pulse got %b exp 0", bus.frame_valid);
    end
    checks++;
    if (bus.frame_cnt !== 16'd1) begin
      errors++; $display("FAIL single_cnt got %0d exp 1", bus.frame_cnt);
    end
    bus.frame_ready = 1'b0;
  endtask

  task automatic test_stream();
    int frames_seen;
    frames_seen = 0;
    do_reset();
    bus.frame_ready = 1'b1;
    for (int i = 0; i < 1024 + 8; i++) begin
      bus.fir_valid = (i < 1024);
      bus.fir_d     = W'(i);
      step();
      if (bus.frame_valid === 1'b1) begin
        checks++;
        if (bus.frame_data !== ramp(frames_seen * N)) begin
          errors++;
          $display("FAIL stream_frame%0d got %h exp %h", frames_seen, bus.frame_data,
                   ramp(frames_seen * N));
        end
        frames_seen++;
      end
    end
    bus.fir_valid = 1'b0;
    checks++;
    if (frames_seen != 64) begin
      errors++; $display("FAIL stream_frames got %0d exp 64", frames_seen);
    end
    checks++;
    if (bus.frame_cnt !== 16'd64) begin
      errors++; $display("FAIL stream_cnt got %0d exp 64", bus.frame_cnt);
    end
    checks++;
    if (bus.overflow !== 1'b0) begin
      errors++; $display("FAIL stream_overflow got %b exp 0", bus.overflow);
    end
    bus.frame_ready = 1'b0;
  endtask

  task automatic test_held_overflow();
    do_reset();
    for (int i = 0; i < 20; i++) push(i);
    checks++;
    if (bus.frame_data !== ramp(0)) begin
      errors++; $display("FAIL held_early_data got %h exp %h", bus.frame_data, ramp(0));
    end
    for (int i = 20; i < 48; i++) push(i);
    checks++;
    if (bus.frame_valid !== 1'b1) begin
      errors++; $display("FAIL held_valid got %b exp 1", bus.frame_valid);
    end
    checks++;
    if (bus.frame_data !== ramp(0)) begin
      errors++; $display("FAIL held_data got %h exp %h", bus.frame_data, ramp(0));
    end
    checks++;
    if (bus.overflow !== 1'b1) begin
      errors++; $display("FAIL held_overflow got %b exp 1", bus.overflow);
    end
    bus.frame_ready = 1'b1;
    step();
    checks++;
    if (bus.frame_valid !== 1'b1 || bus.frame_data !== ramp(16)) begin
      errors++;
      $display("FAIL held_second got v=%b %h exp v=1 %h", bus.frame_valid, bus.frame_data,
               ramp(16));
    end
    step();
    bus.frame_ready = 1'b0;
    checks++;
    if (bus.frame_valid !== 1'b0) begin
      errors++; $display("FAIL held_drained got %b exp 0", bus.frame_valid);
    end
    checks++;
    if (bus.frame_cnt !== 16'd2) begin
      errors++; $display("FAIL held_cnt got %0d exp 2", bus.frame_cnt);
    end
  endtask

  task automatic test_back_to_back();
    // Completion of bank 1 on the same edge bank 0 is handed off.
    do_reset();
    for (int i = 0; i < 31; i++) push(i);
    bus.frame_ready = 1'b1;
    push(31);
    checks++;
    if (bus.frame_cnt !== 16'd1 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL simul_edge got cnt=%0d ovf=%b exp cnt=1 ovf=0", bus.frame_cnt,
               bus.overflow);
    end
    step();
    checks++;
    if (bus.frame_valid !== 1'b1 || bus.frame_data !== ramp(16)) begin
      errors++;
      $display("FAIL simul_second got v=%b %h exp v=1 %h", bus.frame_valid, bus.frame_data,
               ramp(16));
    end
    bus.frame_ready = 1'b0;

    // Both banks full; a sample arriving with the handoff passes through into the freed bank.
    do_reset();
    for (int i = 0; i < 32; i++) push(i);
    bus.frame_ready = 1'b1;
    push(100);
    bus.frame_ready = 1'b0;
    checks++;
    if (bus.overflow !== 1'b0) begin
      errors++; $display("FAIL pass_overflow got %b exp 0", bus.overflow);
    end
    checks++;
    if (bus.frame_valid !== 1'b1 || bus.frame_data !== ramp(16)) begin
      errors++;
      $display("FAIL pass_next got v=%b %h exp v=1 %h", bus.frame_valid, bus.frame_data,
               ramp(16));
    end
    for (int i = 101; i < 116; i++) push(i);
    bus.frame_ready = 1'b1;
    step();
    bus.frame_ready = 1'b0;
    checks++;
    if (bus.frame_data !== ramp(100)) begin
      errors++; $display("FAIL pass_data got %h exp %h", bus.frame_data, ramp(100));
    end
    checks++;
    if (bus.frame_cnt !== 16'd2 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL pass_cnt got cnt=%0d ovf=%b exp cnt=2 ovf=0", bus.frame_cnt,
               bus.overflow);
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    bus.frame_ready = 1'b1;
    for (int i = 0; i < N; i++) push(i);
    step();
    step();
    bus.frame_ready = 1'b0;
    for (int i = 16; i < 39; i++) push(i);
    checks++;
    if (bus.frame_valid !== 1'b1 || bus.frame_cnt !== 16'd1) begin
      errors++;
      $display("FAIL mid_pre got v=%b cnt=%0d exp v=1 cnt=1", bus.frame_valid, bus.frame_cnt);
    end
    rst = 1'b0;
    #2;
    checks++;
    if (bus.frame_valid !== 1'b0 || bus.frame_cnt !== 16'd0 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL mid_async got v=%b cnt=%0d ovf=%b exp 0 0 0", bus.frame_valid,
               bus.frame_cnt, bus.overflow);
    end
    step();
    rst = 1'b1;
    step();
    bus.frame_ready = 1'b1;
    for (int i = 200; i < 216; i++) push(i);
    step();
    checks++;
    if (bus.frame_valid !== 1'b1 || bus.frame_data !== ramp(200)) begin
      errors++;
      $display("FAIL mid_clean got v=%b %h exp v=1 %h", bus.frame_valid, bus.frame_data,
               ramp(200));
    end
    step();
    bus.frame_ready = 1'b0;
    checks++;
    if (bus.frame_cnt !== 16'd1) begin
      errors++; $display("FAIL mid_cnt got %0d exp 1", bus.frame_cnt);
    end
  endtask

`ifdef FIR_FRAME_FLUSH_EN
  task automatic test_flush();
    logic [N*W-1:0] exp;
    do_reset();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    step();
    step();
    checks++;
    if (bus.frame_valid !== 1'b0) begin
      errors++; $display("FAIL flush_empty got %b exp 0", bus.frame_valid);
    end
    for (int i = 0; i < 5; i++) push(16'hffff);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    step();
    exp = '0;
    for (int k = 0; k < 5; k++) exp[k*W +: W] = 16'hffff;
    checks++;
    if (bus.frame_valid !== 1'b1 || bus.frame_data !== exp) begin
      errors++;
      $display("FAIL flush_pad got v=%b %h exp v=1 %h", bus.frame_valid, bus.frame_data, exp);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_stream();
    test_held_overflow();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef FIR_FRAME_FLUSH_EN
    test_flush();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
